idle_detector: RTL

- Receive-side link-state block that directly feeds the recirculation gate.
- Watches the four de-striped lanes for COM training and IDLE symbols and generates the IDL qualifier.
- Registers the lane data and valid bits by one cycle so that IDL and the data are cycle-aligned.
- The first payload byte after training reaches L1 with IDL=1 and is not zeroed.

---
 rtl/idle_detector_pkg.sv | 16 +
 rtl/idle_detector.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/idle_detector_pkg.sv
// Shared link-layer constants: symbols, lane count and FSM encoding.
package idle_detector_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [7:0] COM_SYM  = 8'hBC;
  localparam logic [7:0] IDLE_SYM = 8'h7C;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_BAD    = 2'd3
  } link_st_e;

endpackage

// File: rtl/idle_detector.sv
// Lane COM/IDLE watcher producing IDL, with a one-cycle aligned data path.
module idle_detector
  import idle_detector_pkg::*;
#(
  parameter logic [7:0] COM_S  = COM_SYM,
  parameter logic [7:0] IDLE_S = IDLE_SYM,
  parameter int unsigned COM_COUNT  = 4,
  parameter int unsigned IDLE_COUNT = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3,
  output logic       IDL,
  output logic [1:0] state,
  output logic       align_err
);

  localparam logic [CNT_W-1:0] COM_LAST  = CNT_W'(COM_COUNT - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [LANES-1:0][7:0] lane;
  logic [LANES-1:0]      vld;
  logic [LANES-1:0]      is_com;
  logic [LANES-1:0]      is_idle;
  logic all_v, all_com, any_com, idle_cyc;

  link_st_e st_q, st_d;
  logic [CNT_W-1:0] com_cnt_q, com_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic idl_q, idl_d;
  logic err_q, err_d;
  logic [LANES-1:0][7:0] dat_q;
  logic [LANES-1:0]      vld_q;

  assign lane = {data_in3, data_in2, data_in1, data_in0};
  assign vld  = {valid3, valid2, valid1, valid0};

  always_comb begin
    is_com  = '0;
    is_idle = '0;
    for (int i = 0; i < LANES; i++) begin
      is_com[i]  = lane[i] == COM_S;
      is_idle[i] = !vld[i] || (lane[i] == IDLE_S);
    end
  end

  assign all_v    = &vld;
  assign all_com  = all_v && (&is_com);
  assign any_com  = |(vld & is_com);
  assign idle_cyc = &is_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= ST_SEARCH;
      com_cnt_q  <= '0;
      idle_cnt_q <= '0;
      idl_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      vld_q      <= '0;
    end else begin
      st_q       <= st_d;
      com_cnt_q  <= com_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      idl_q      <= idl_d;
      err_q      <= err_d;
      dat_q      <= lane;
      vld_q      <= vld;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_SEARCH: begin
        if (all_com && com_cnt_q == COM_LAST)
          st_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (all_com)
          st_d = ST_ALIGN;
        else if (all_v && !any_com)
          st_d = ST_ACTIVE;
        else if (any_com)
          st_d = ST_SEARCH;
      end
      ST_ACTIVE: begin
        if (all_com)
          st_d = ST_SEARCH;
        else if (idle_cyc && idle_cnt_q == IDLE_LAST)
          st_d = ST_SEARCH;
      end
      default: st_d = ST_SEARCH;
    endcase
  end

  // Counters only run in their own state and clear on any transition.
  always_comb begin
    com_cnt_d  = '0;
    idle_cnt_d = '0;
    err_d      = 1'b0;
    idl_d      = st_d == ST_ACTIVE;
    if (st_d == st_q) begin
      if (st_q == ST_SEARCH && all_com)
        com_cnt_d = (com_cnt_q == CNT_MAX) ? com_cnt_q : com_cnt_q + 1'b1;
      if (st_q == ST_ACTIVE && idle_cyc)
        idle_cnt_d = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + 1'b1;
    end
    if (st_q == ST_ALIGN && !all_com && any_com)
      err_d = 1'b1;
  end

  assign data_out0  = dat_q[0];
  assign data_out1  = dat_q[1];
  assign data_out2  = dat_q[2];
  assign data_out3  = dat_q[3];
  assign valid_out0 = vld_q[0];
  assign valid_out1 = vld_q[1];
  assign valid_out2 = vld_q[2];
  assign valid_out3 = vld_q[3];
  assign IDL        = idl_q;
  assign state      = st_q;
  assign align_err  = err_q;

endmodule
